// File: rtl/idct_row_scatter8.sv
// Round-robin dealer: one serial coefficient stream onto eight IDCT row lanes,
// with EOS broadcast to every lane and zero padding of partial rows.
module idct_row_scatter8 #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] s_d,
  input  logic         s_e,
  input  logic         s_v,
  output logic         s_b,
  output logic [W-1:0] a0_d,
  output logic [W-1:0] a1_d,
  output logic [W-1:0] a2_d,
  output logic [W-1:0] a3_d,
  output logic [W-1:0] a4_d,
  output logic [W-1:0] a5_d,
  output logic [W-1:0] a6_d,
  output logic [W-1:0] a7_d,
  output logic         a0_e,
  output logic         a1_e,
  output logic         a2_e,
  output logic         a3_e,
  output logic         a4_e,
  output logic         a5_e,
  output logic         a6_e,
  output logic         a7_e,
  output logic         a0_v,
  output logic         a1_v,
  output logic         a2_v,
  output logic         a3_v,
  output logic         a4_v,
  output logic         a5_v,
  output logic         a6_v,
  output logic         a7_v,
  input  logic         a0_b,
  input  logic         a1_b,
  input  logic         a2_b,
  input  logic         a3_b,
  input  logic         a4_b,
  input  logic         a5_b,
  input  logic         a6_b,
  input  logic         a7_b,
  output logic [15:0]  row_cnt,
  output logic         err
);

  localparam int unsigned NL = 8;
  localparam int unsigned PW = 3;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAD   = 2'd1,
    ST_BCAST = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NL-1:0]   mask_q, mask_d;
  logic [CW-1:0]   row_q, row_d;
  logic            err_q, err_d;

  logic [W-1:0]    lane_d_q [NL];
  logic [NL-1:0]   lane_e_q;
  logic [NL-1:0]   full_q;
  logic [NL-1:0]   lane_b;
  logic [NL-1:0]   free;

  // All lanes loaded in one cycle share the same payload.
  logic [NL-1:0]   load;
  logic [W-1:0]    load_d;
  logic            load_e;

  assign lane_b = {a7_b, a6_b, a5_b, a4_b, a3_b, a2_b, a1_b, a0_b};
  assign free   = ~full_q | ~lane_b;

  // Next-state, lane load selection and upstream back-pressure.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    row_d   = row_q;
    err_d   = err_q;
    load    = '0;
    load_d  = '0;
    load_e  = 1'b0;
    s_b     = 1'b1;
    case (state_q)
      ST_RUN: begin
        s_b = ~free[ptr_q];
        if (s_v && free[ptr_q]) begin
          if (!s_e) begin
            load[ptr_q] = 1'b1;
            load_d      = s_d;
            ptr_d       = ptr_q + PW'(1);
            if (ptr_q == PW'(NL - 1)) row_d = row_q + CW'(1);
          end else begin
            mask_d = '0;
            if (ptr_q == '0) begin
              state_d = ST_BCAST;
            end else begin
              err_d   = 1'b1;
              state_d = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        if (free[ptr_q]) begin
          load[ptr_q] = 1'b1;
          ptr_d       = ptr_q + PW'(1);
          if (ptr_q == PW'(NL - 1)) begin
            row_d   = row_q + CW'(1);
            mask_d  = '0;
            state_d = ST_BCAST;
          end
        end
      end
      ST_BCAST: begin
        load   = ~mask_q & free;
        load_e = 1'b1;
        mask_d = mask_q | free;
        if (mask_d == '1) begin
          ptr_d   = '0;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
      mask_q  <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

  // Lane output registers; a load wins over a same-cycle drain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NL; k++) lane_d_q[k] <= '0;
      lane_e_q <= '0;
      full_q   <= '0;
    end else begin
      for (int k = 0; k < NL; k++) begin
        if (load[k]) begin
          lane_d_q[k] <= load_d;
          lane_e_q[k] <= load_e;
          full_q[k]   <= 1'b1;
        end else if (full_q[k] && !lane_b[k]) begin
          full_q[k]   <= 1'b0;
        end
      end
    end
  end

  assign a0_d = lane_d_q[0];
  assign a1_d = lane_d_q[1];
  assign a2_d = lane_d_q[2];
  assign a3_d = lane_d_q[3];
  assign a4_d = lane_d_q[4];
  assign a5_d = lane_d_q[5];
  assign a6_d = lane_d_q[6];
  assign a7_d = lane_d_q[7];
  assign {a7_e, a6_e, a5_e, a4_e, a3_e, a2_e, a1_e, a0_e} = lane_e_q;
  assign {a7_v, a6_v, a5_v, a4_v, a3_v, a2_v, a1_v, a0_v} = full_q;
  assign row_cnt = row_q;
  assign err     = err_q;

endmodule

// File: doc/idct_row_scatter8.md
# idct_row_scatter8

Stream transmitter that feeds an 8-lane IDCT row page. It takes one serial 16-bit coefficient stream and deals consecutive tokens round-robin onto eight lanes a0..a7, one coefficient per lane per row. It also broadcasts end-of-stream to every lane and pads incomplete rows. It sits directly upstream of the 1-D IDCT page and drives that page's a-side inputs.

## Interface
Parameters:
- W, 16, data width of input and every lane.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_d  in  W  input token data.
- s_e  in  1  input end-of-stream flag; token is EOS when s_e=1, s_d ignored.
- s_v  in  1  input token valid.
- s_b  out  1  input back-pressure; a token transfers when s_v=1 and s_b=0.
- a0_d..a7_d  out  W each  lane data.
- a0_e..a7_e  out  1 each  lane EOS flag.
- a0_v..a7_v  out  1 each  lane valid.
- a0_b..a7_b  in  1 each  lane back-pressure; a lane transfers when ak_v=1 and ak_b=0.
- row_cnt  out  16  completed rows (8 data tokens dealt, padded or not), wraps at 65535->0.
- err  out  1  sticky: EOS arrived with a partial row.

## Operation
- Each lane k has one output register holding {d, e} and a full flag; ak_v = full_k.
- Lane k is *free* this cycle when full_k=0, or full_k=1 and ak_b=0 (drains this cycle).
- A 3-bit pointer ptr selects the target lane. FSM states are RUN, PAD and BCAST.
- RUN, data token (s_e=0):
  - s_b = ~free_ptr.
  - On transfer, load lane ptr with {s_d, 0} and increment ptr.
  - When ptr wraps 7->0, row_cnt increments.
- RUN, EOS token (s_e=1):
  - Accepted when s_b=0, with the same free rule as a data token.
  - If ptr=0: consume the EOS, go to BCAST with mask=0.
  - If ptr!=0: consume the EOS, set err=1, go to PAD.
- PAD:
  - s_b=1.
  - Load {0, 0} into lane ptr when it is free, then increment ptr.
  - On the 7->0 wrap, increment row_cnt and go to BCAST with mask=0.
- BCAST:
  - s_b=1.
  - Each cycle, load {0, 1} into every lane k with mask_k=0 and free_k=1, then set mask_k.
  - When mask becomes 8'hFF, go to RUN with ptr=0.
- Lane register ordering: a lane loaded in the same cycle it drains holds the new token next cycle. No token is ever dropped or duplicated.
- err is cleared only by reset.

## Timing
- Reset values: all ak_v=0, ak_e=0, ak_d=0, state=RUN, ptr=0, mask=0, row_cnt=0, err=0. s_b=0 immediately after reset, because lane 0 is empty.
- Reset asserted mid-operation: all lane contents discarded, outputs return to reset values asynchronously.
- Latency: an input token accepted at cycle t is visible on its lane at cycle t+1.
- Throughput: 1 token/cycle sustained when all ak_b=0.
- s_b is combinational from state, ptr, full and ak_b. There is no combinational path from s_v or s_d.
- An EOS with ptr=0 appears on all lanes no earlier than t+1 after acceptance. Lanes load independently, so EOS may appear on different lanes in different cycles under back-pressure.
- PAD takes at least (8-ptr) cycles. BCAST takes at least 1 cycle.

## Test plan
- Reset, then send data 1..8 with all ak_b=0 and s_v held high -> ak_d=k+1 each valid for one cycle, on lanes 0..7 in cycles 1..8; s_b stays 0; row_cnt=1.
- Hold a3_b=1 and send 16 tokens -> s_b=1 while ptr=3 and lane 3 is full. Release a3_b -> all 16 tokens delivered in order (lane k gets k+1 then k+9); row_cnt=2.
- Send 8 data tokens then EOS, with all lanes ready -> each lane emits its data, then one token with e=1; err=0; row_cnt=1; s_b returns to 0 after BCAST.
- Send 3 data tokens then EOS -> lanes 3..7 emit d=0,e=0; then all 8 lanes emit e=1; err=1; row_cnt=1.
- During BCAST hold a5_b=1 for 4 cycles -> the other lanes get EOS immediately; lane 5 gets EOS after release; FSM stays in BCAST until then and s_b=1 throughout.
- Assert reset mid-PAD -> all ak_v=0, err=0, row_cnt=0, ptr=0. After release, token 0x1234 appears on lane 0.
